// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA timing generator and its consumers.
// Counters, syncs and the game tick flow out of the generator; pause flows in.
interface vga_timing_gen_if;
  logic [9:0] Xpos;
  logic [9:0] Ypos;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       frame_tick;
  logic       refresh;
  logic       pause;

  modport master (
    output Xpos, Ypos, hsync, vsync, video_on, frame_tick, refresh,
    input  pause
  );

  modport slave (
    input  Xpos, Ypos, hsync, vsync, video_on, frame_tick, refresh,
    output pause
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster counters, sync/visible decodes and a frame-divided game tick.
// All outputs are registered and decoded from next-state counters so they share one cycle.
module vga_timing_gen #(
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned H_VIS       = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned V_VIS       = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned REFRESH_DIV = 6
) (
  input  logic             vga_clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_VIS + H_FP;
  localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_VIS + V_FP;

  localparam logic [9:0] HMax    = 10'(H_TOTAL - 1);
  localparam logic [9:0] VMax    = 10'(V_TOTAL - 1);
  localparam logic [9:0] HSyncW  = 10'(H_SYNC);
  localparam logic [9:0] VSyncW  = 10'(V_SYNC);
  localparam logic [9:0] HVisLo  = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HVisHi  = 10'(H_SYNC + H_BP + H_VIS);
  localparam logic [9:0] VVisLo  = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VVisHi  = 10'(V_SYNC + V_BP + V_VIS);
  localparam logic [7:0] DivMax  = 8'(REFRESH_DIV - 1);

  logic       x_wrap;
  logic       y_wrap;
  logic       frame_wrap;
  logic [9:0] x_d;
  logic [9:0] y_d;
  logic [7:0] frame_div_q;
  logic [7:0] frame_div_d;
  logic       hsync_d;
  logic       vsync_d;
  logic       video_on_d;
  logic       refresh_d;

  always_comb begin
    x_wrap     = (vga.Xpos == HMax);
    y_wrap     = (vga.Ypos == VMax);
    frame_wrap = x_wrap && y_wrap;

    x_d = x_wrap ? 10'd0 : vga.Xpos + 10'd1;
    y_d = vga.Ypos;
    if (x_wrap) begin
      y_d = y_wrap ? 10'd0 : vga.Ypos + 10'd1;
    end

    // Decode from next-state counters so the registered flags line up with Xpos/Ypos.
    hsync_d    = (x_d >= HSyncW);
    vsync_d    = (y_d >= VSyncW);
    video_on_d = (x_d >= HVisLo) && (x_d < HVisHi) && (y_d >= VVisLo) && (y_d < VVisHi);

    frame_div_d = frame_div_q;
    refresh_d   = 1'b0;
    if (frame_wrap && !vga.pause) begin
      if (frame_div_q == DivMax) begin
        frame_div_d = 8'd0;
        refresh_d   = 1'b1;
      end else begin
        frame_div_d = frame_div_q + 8'd1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (!rst_n) begin
      vga.Xpos       <= 10'd0;
      vga.Ypos       <= 10'd0;
      vga.hsync      <= 1'b0;
      vga.vsync      <= 1'b0;
      vga.video_on   <= 1'b0;
      vga.frame_tick <= 1'b0;
      vga.refresh    <= 1'b0;
      frame_div_q    <= 8'd0;
    end else begin
      vga.Xpos       <= x_d;
      vga.Ypos       <= y_d;
      vga.hsync      <= hsync_d;
      vga.vsync      <= vsync_d;
      vga.video_on   <= video_on_d;
      vga.frame_tick <= frame_wrap;
      vga.refresh    <= refresh_d;
      frame_div_q    <= frame_div_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size instance for line/vertical-edge timing, shrunken instances
// (16x10 raster) for whole-frame, game-tick, pause and mid-frame reset behaviour.
module tb_vga_timing_gen;

  logic vga_clk = 1'b0;
  logic rst_n   = 1'b0;
  always #20 vga_clk = ~vga_clk;

  vga_timing_gen_if big_if ();
  vga_timing_gen_if sml_if ();
  vga_timing_gen_if one_if ();

  vga_timing_gen u_big (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .vga     (big_if.master)
  );

  // 16 pixels/line (sync 0..3, visible 6..13), 10 lines/frame (sync 0..1, visible 5..8).
  vga_timing_gen #(
    .H_SYNC(4), .H_BP(2), .H_VIS(8), .H_FP(2),
    .V_SYNC(2), .V_BP(3), .V_VIS(4), .V_FP(1),
    .REFRESH_DIV(3)
  ) u_sml (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .vga     (sml_if.master)
  );

  vga_timing_gen #(
    .H_SYNC(4), .H_BP(2), .H_VIS(8), .H_FP(2),
    .V_SYNC(2), .V_BP(3), .V_VIS(4), .V_FP(1),
    .REFRESH_DIV(1)
  ) u_one (
    .vga_clk (vga_clk),
    .rst_n   (rst_n),
    .vga     (one_if.master)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned cyc      = 0;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
    cyc++;
  endtask

  localparam int unsigned None = 32'hFFFF_FFFF;

  initial begin
    int unsigned b_hlow0 = 0, b_hfirst_hi = None, b_von0 = 0, b_vlow = 0;
    int unsigned b_von_first = None, b_vfx = 0, b_vfy = 0, b_von35 = 0, b_vlast35 = 0;
    int unsigned b_ft = 0;
    int unsigned s_vlow = 0, s_hlow = 0, s_von = 0, s_von_first = None, s_von_last = 0;
    int unsigned s_ft_first = None, s_ft = 0, s_ref = 0, s_ref1 = None, s_ref2 = None;
    int unsigned s_ref_bad = 0, o_mis = 0, o_ref = 0;
    int unsigned p_ref = 0, p_ref1 = None, p_ft = 0;
    int unsigned m_ref1 = None, m_ft = 0;
    logic s_ref_prev = 1'b0;

    big_if.pause = 1'b0;
    sml_if.pause = 1'b0;
    one_if.pause = 1'b0;

    // Reset held for three cycles.
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_xpos",     big_if.Xpos, 0);
    check("rst_ypos",     big_if.Ypos, 0);
    check("rst_hsync",    big_if.hsync, 0);
    check("rst_vsync",    big_if.vsync, 0);
    check("rst_video_on", big_if.video_on, 0);
    check("rst_refresh",  big_if.refresh, 0);
    check("rst_ftick",    big_if.frame_tick, 0);
    check("rst_sml_xy",   {sml_if.Xpos, sml_if.Ypos}, 0);

    // Phase 1: c counts edges since release; c=0 is the last reset-state cycle.
    cyc   = 0;
    rst_n = 1'b1;
    for (int c = 0; c < 28800; c++) begin
      if (c != 0) step();
      if (c == 1) check("release_xpos", big_if.Xpos, 1);
      if (c == 799) check("line_end_xy", {big_if.Xpos, big_if.Ypos}, {10'd799, 10'd0});
      if (c == 800) check("line_wrap_xy", {big_if.Xpos, big_if.Ypos}, {10'd0, 10'd1});
      if (c < 800) begin
        if (!big_if.hsync) b_hlow0++;
        if (big_if.video_on) b_von0++;
      end
      if (big_if.hsync && b_hfirst_hi == None) b_hfirst_hi = c;
      if (c < 2400 && !big_if.vsync) b_vlow++;
      if (big_if.video_on && b_von_first == None) begin
        b_von_first = c;
        b_vfx = big_if.Xpos;
        b_vfy = big_if.Ypos;
      end
      if (c >= 28000 && big_if.video_on) begin
        b_von35++;
        b_vlast35 = big_if.Xpos;
      end
      if (big_if.frame_tick) b_ft++;

      if (c <= 1000) begin
        if (c < 160) begin
          if (!sml_if.vsync) s_vlow++;
          if (!sml_if.hsync) s_hlow++;
          if (sml_if.video_on) begin
            s_von++;
            s_von_last = c;
            if (s_von_first == None) s_von_first = c;
          end
        end
        if (sml_if.frame_tick) begin
          s_ft++;
          if (s_ft_first == None) s_ft_first = c;
        end
        if (sml_if.refresh) begin
          s_ref++;
          if (s_ref1 == None) s_ref1 = c;
          else if (s_ref2 == None) s_ref2 = c;
          if (sml_if.Xpos != 0 || sml_if.Ypos != 0 || s_ref_prev) s_ref_bad++;
        end
        s_ref_prev = sml_if.refresh;
        if (one_if.refresh != one_if.frame_tick) o_mis++;
        if (one_if.refresh) o_ref++;
      end
    end
    check("line0_hsync_low",   b_hlow0, 96);
    check("line0_hsync_rise",  b_hfirst_hi, 96);
    check("line0_video_on",    b_von0, 0);
    check("vsync_low_cycles",  b_vlow, 1600);
    check("first_von_cycle",   b_von_first, 28144);
    check("first_von_xy",      {b_vfx[9:0], b_vfy[9:0]}, {10'd144, 10'd35});
    check("line35_von_count",  b_von35, 640);
    check("line35_last_von_x", b_vlast35, 783);
    check("big_no_ftick",      b_ft, 0);

    check("sml_vsync_low",  s_vlow, 32);
    check("sml_hsync_low",  s_hlow, 40);
    check("sml_von_count",  s_von, 32);
    check("sml_von_first",  s_von_first, 86);
    check("sml_von_last",   s_von_last, 141);
    check("sml_ftick_first", s_ft_first, 160);
    check("sml_ftick_count", s_ft, 6);
    check("sml_ref_count",  s_ref, 2);
    check("sml_ref_first",  s_ref1, 480);
    check("sml_ref_second", s_ref2, 960);
    check("sml_ref_shape",  s_ref_bad, 0);
    check("div1_ref_eq_ft", o_mis, 0);
    check("div1_ref_count", o_ref, 6);

    // Phase 2: pause held across frame wraps 3 and 4 (edges 480 and 640).
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cyc   = 0;
    for (int c = 0; c <= 1300; c++) begin
      if (c != 0) step();
      if (sml_if.frame_tick) p_ft++;
      if (sml_if.refresh) begin
        p_ref++;
        if (p_ref1 == None) p_ref1 = c;
      end
      if (c == 400) sml_if.pause = 1'b1;
      if (c == 700) sml_if.pause = 1'b0;
    end
    check("pause_ref_first", p_ref1, 800);
    check("pause_ref_count", p_ref, 2);
    check("pause_ftick_count", p_ft, 8);

    // Phase 3: reset pulse mid-frame after the divider has advanced to 2.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    cyc   = 0;
    for (int c = 1; c <= 392; c++) step();
    check("mid_pre_xy", {sml_if.Xpos, sml_if.Ypos}, {10'd8, 10'd4});
    rst_n = 1'b0;
    step();
    check("mid_rst_xy",   {sml_if.Xpos, sml_if.Ypos}, 0);
    check("mid_rst_ftick", sml_if.frame_tick, 0);
    check("mid_rst_ref",   sml_if.refresh, 0);
    rst_n = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      step();
      if (sml_if.frame_tick) m_ft++;
      if (sml_if.refresh && m_ref1 == None) m_ref1 = c;
    end
    check("mid_ref_first",  m_ref1, 480);
    check("mid_ftick_count", m_ft, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
